// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch front end: issues word-aligned fetch requests on a
// valid/ready memory port, tracks in-flight requests with a PC-tag FIFO,
// buffers returned instructions with their PCs, and flushes on redirect.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned-redirect halt).
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            misalign_err
);

    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam int             PW      = $clog2(DEPTH);
    localparam logic [CW:0]    DEPTH_C = (CW+1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   tag_rd;
    logic [PW-1:0]   tag_wr;
    logic            halted;

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [31:0]     data_mem [DEPTH];
    logic [XLEN-1:0] tag_mem  [DEPTH];

    logic            req_fire;
    logic            rsp_fire;
    logic            push;
    logic            pop;
    logic [CW:0]     credit_used;
    logic [CW-1:0]   outstanding_nxt;
    logic [XLEN-1:0] target;
    logic            bad_align;

    // Buffered plus in-flight entries may never exceed the FIFO size, so a
    // returning response always finds a free slot.
    assign credit_used    = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = reset && !halted && (credit_used < DEPTH_C);
    assign imem_req_addr  = fetch_pc;

    assign req_fire = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol violation; ignore it.
    assign rsp_fire = imem_rsp_valid && (outstanding != '0);
    // Responses are dropped while stale ones remain, and in a redirect cycle.
    assign push     = rsp_fire && (discard == '0) && !redirect_valid;
    assign pop      = inst_valid && inst_ready;

    assign inst_valid = (count != '0);
    assign inst_data  = inst_valid ? data_mem[rd_ptr] : '0;
    assign inst_pc    = inst_valid ? pc_mem[rd_ptr]   : '0;
    assign misalign_err = halted;

    assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(rsp_fire);
    assign target          = {redirect_pc[XLEN-1:2], 2'b00};

`ifdef FETCH_MISALIGN_CHECK_EN
    assign bad_align = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign bad_align = 1'b0;
`endif

    // Sequencer state: fetch PC, credit counters, FIFO and tag pointers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
            halted      <= 1'b0;
        end else begin
            outstanding <= outstanding_nxt;
            if (req_fire) tag_wr <= tag_wr + PW'(1);
            if (rsp_fire) tag_rd <= tag_rd + PW'(1);
            if (pop)      rd_ptr <= rd_ptr + PW'(1);
            if (push)     wr_ptr <= wr_ptr + PW'(1);
            if (redirect_valid) begin
                // Everything still in flight after this cycle is old-path.
                fetch_pc <= target;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                discard  <= outstanding_nxt;
                if (bad_align) halted <= 1'b1;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
                count <= count + CW'(push) - CW'(pop);
                if (rsp_fire && (discard != '0)) discard <= discard - CW'(1);
            end
        end
    end

    // Tag and instruction storage; contents are qualified by the pointers
    always_ff @(posedge clk) begin
        if (req_fire) tag_mem[tag_wr] <= fetch_pc;
        if (push) begin
            pc_mem[wr_ptr]   <= tag_mem[tag_rd];
            data_mem[wr_ptr] <= imem_rsp_data;
        end
    end

    // Responses must always match an outstanding request
    always_ff @(posedge clk) begin
        if (reset && imem_rsp_valid) assert (outstanding != '0);
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit: memory model with random in-order
// latency, expected program-order fetch stream, directed and random phases.
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        misalign_err;

    fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    // Memory model: accepted addresses with the cycle their response is due
    logic [31:0] memq[$];
    int          dueq[$];
    int          cyc, last_due, lat_lo, lat_hi;
    int          errors, checks, pops, accepts;
    logic [31:0] exp_pc, exp_req;
    bit          halted_m, post_redir, chk_stream;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Assert reset, check reset outputs, release on a falling clock edge
    task automatic do_reset();
        reset          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        memq.delete();
        dueq.delete();
        last_due   = 0;
        halted_m   = 1'b0;
        post_redir = 1'b0;
        exp_pc     = RESET_PC;
        exp_req    = RESET_PC;
        #1;
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_req_addr",  imem_req_addr,  RESET_PC);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst_data", inst_data, 0);
        check("rst_inst_pc",   inst_pc, 0);
        check("rst_misalign",  misalign_err, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        cyc   = 0;
    endtask

    // One clock cycle: drive inputs at the falling edge, check, update model
    task automatic cycle(input bit rdy, input bit irdy, input bit redir, input logic [31:0] rpc);
        bit          req_fire;
        int          due;
        logic [31:0] t;
        if (memq.size() > 0 && dueq[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(memq[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        imem_req_ready = rdy;
        inst_ready     = irdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
        if (chk_stream) check("stream_valid", inst_valid, (cyc >= 2) ? 1 : 0);
        if (post_redir) begin
            check("redir_flush", inst_valid, 0);
            check("redir_req_valid", imem_req_valid, (!halted_m && memq.size() < DEPTH) ? 1 : 0);
        end
        if (halted_m) begin
            check("halt_req_valid", imem_req_valid, 0);
            check("halt_inst_valid", inst_valid, 0);
        end
        check("misalign_flag", misalign_err, halted_m);
        req_fire = imem_req_valid && rdy;
        if (imem_rsp_valid) begin
            void'(memq.pop_front());
            void'(dueq.pop_front());
        end
        if (req_fire) begin
            check("req_addr", imem_req_addr, exp_req);
            due = cyc + $urandom_range(lat_hi, lat_lo);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            memq.push_back(imem_req_addr);
            dueq.push_back(due);
            exp_req = exp_req + 32'd4;
            accepts++;
        end
        if (inst_valid && irdy) begin
            check("inst_pc", inst_pc, exp_pc);
            check("inst_data", inst_data, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        post_redir = redir;
        if (redir) begin
            t = rpc;
`ifdef FETCH_MISALIGN_CHECK_EN
            if (t[1:0] != 2'b00) halted_m = 1'b1;
`endif
            t[1:0]  = 2'b00;
            exp_pc  = t;
            exp_req = t;
        end
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        logic [31:0] t;
        errors = 0; checks = 0; pops = 0; accepts = 0;
        lat_lo = 1; lat_hi = 1; chk_stream = 1'b0;
        reset = 1'b1;
        #2;

        // Zero-wait memory, decode always ready: one instruction per cycle
        do_reset();
        chk_stream = 1'b1;
        for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0);
        chk_stream = 1'b0;

        // Latency 3, decode stalled: credits stop issue after DEPTH requests
        do_reset();
        lat_lo = 3; lat_hi = 3; accepts = 0;
        for (int i = 0; i < 12; i++) cycle(1, 0, 0, 0);
        check("fill_accepts", accepts, DEPTH);
        check("fill_req_valid", imem_req_valid, 0);
        check("fill_inst_valid", inst_valid, 1);
        cycle(1, 1, 0, 0);
        check("pop_reenables_req", imem_req_valid, 1);

        // Redirect to 0x100 with two requests in flight
        do_reset();
        lat_lo = 3; lat_hi = 3;
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        pops = 0;
        cycle(0, 1, 1, 32'h100);
        for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0);
        check("redir_progress", (pops > 0) ? 1 : 0, 1);

        // Redirect coinciding with a request accept and a response
        do_reset();
        lat_lo = 2; lat_hi = 2;
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        pops = 0;
        cycle(1, 1, 1, 32'h200);
        for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0);
        check("coincide_progress", (pops > 0) ? 1 : 0, 1);

        // Address wrap at the top of the address space
        lat_lo = 1; lat_hi = 1;
        cycle(1, 1, 1, 32'hFFFF_FFFC);
        for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0);

        // Misaligned redirect target
        pops = 0;
        cycle(1, 1, 1, 32'h102);
        for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0);
`ifndef FETCH_MISALIGN_CHECK_EN
        check("misalign_resume", (pops > 0) ? 1 : 0, 1);
`endif

        // Random traffic with occasional redirects and one mid-run reset
        do_reset();
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) do_reset();
            t = $urandom;
            t[1:0] = 2'b00;
            cycle(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 32) == 0, t);
        end

        // Drain with everything ready: fetch must keep making progress
        pops = 0;
        for (int i = 0; i < 30; i++) cycle(1, 1, 0, 0);
        check("drain_progress", (pops > 0) ? 1 : 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
